// File: rtl/ahb_pkg.sv
// Shared types and constants for the 4-bit-address, 16-bit-data AHB-Lite bus
// between the host sequencer and the FIR peripheral slave.
package ahb_pkg;

  localparam int AHB_ADDR_W = 4;
  localparam int AHB_DATA_W = 16;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_NONSEQ = 2'b10
  } htrans_t;

  localparam logic HSIZE_BYTE = 1'b0;
  localparam logic HSIZE_HALF = 1'b1;

  // One pipeline stage: a transfer sitting in either the address or data phase.
  typedef struct packed {
    logic                  valid;
    logic [AHB_ADDR_W-1:0] addr;
    logic                  write;
    logic                  size;
    logic [AHB_DATA_W-1:0] wdata;
  } ahb_xfer_t;

  localparam ahb_xfer_t XFER_EMPTY = '0;

endpackage

// File: rtl/ahb_lane_steer.sv
// Byte-lane steering for the data phase: replicates byte write data onto both
// lanes and extracts/zero-extends the addressed lane of read data.
module ahb_lane_steer
  import ahb_pkg::*;
(
  input  ahb_xfer_t             xfer_i,
  input  logic [AHB_DATA_W-1:0] hrdata_i,
  output logic [AHB_DATA_W-1:0] hwdata_o,
  output logic [AHB_DATA_W-1:0] rdata_o
);

  localparam int HALF_W = AHB_DATA_W / 2;

  always_comb begin
    // NOTE: every output gets a default before any branch, so no path leaves
    // it unassigned and no latch is inferred.
    hwdata_o = '0;
    rdata_o  = '0;
    if (xfer_i.valid && xfer_i.write) begin
      hwdata_o = (xfer_i.size == HSIZE_HALF) ? xfer_i.wdata
                                             : {2{xfer_i.wdata[HALF_W-1:0]}};
    end
    if (xfer_i.valid && !xfer_i.write) begin
      if (xfer_i.size == HSIZE_HALF) begin
        rdata_o = hrdata_i;
      end else if (xfer_i.addr[0]) begin
        rdata_o = {{HALF_W{1'b0}}, hrdata_i[AHB_DATA_W-1:HALF_W]};
      end else begin
        rdata_o = {{HALF_W{1'b0}}, hrdata_i[HALF_W-1:0]};
      end
    end
  end

endmodule

// File: rtl/ahb_lite_master.sv
// Pipelined AHB-Lite manager: turns a valid/ready command stream into
// NONSEQ transfers, honouring wait states and the two-cycle error response.
module ahb_lite_master
  import ahb_pkg::*;
#(
  parameter int ADDR_W = AHB_ADDR_W,
  parameter int DATA_W = AHB_DATA_W
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_size,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              hsel,
  output logic [ADDR_W-1:0] haddr,
  output logic              hsize,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [DATA_W-1:0] hwdata,
  input  logic [DATA_W-1:0] hrdata,
  input  logic              hready,
  input  logic              hresp
);

  ahb_xfer_t         a_q, a_d;
  ahb_xfer_t         d_q, d_d;
  logic              hold_q, hold_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [DATA_W-1:0] steer_rdata;
  logic              drive;
  logic              accept;

  ahb_lane_steer u_steer (
    .xfer_i   (d_q),
    .hrdata_i (hrdata),
    .hwdata_o (hwdata),
    .rdata_o  (steer_rdata)
  );

  // While hold is set the address phase is suppressed so the slave sees IDLE
  // in the second error cycle; the held transfer is replayed afterwards.
  assign drive  = a_q.valid & ~hold_q;
  assign htrans = drive ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign hsel   = drive;
  assign haddr  = drive ? a_q.addr  : '0;
  assign hwrite = drive ? a_q.write : 1'b0;
  assign hsize  = drive ? a_q.size  : 1'b0;

  assign cmd_ready = n_rst & hready & ~hold_q & ~(d_q.valid & hresp);
  assign accept    = cmd_valid & cmd_ready;
  assign busy      = a_q.valid | d_q.valid | hold_q;

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

  always_comb begin
    a_d         = a_q;
    d_d         = d_q;
    hold_d      = hold_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    if (hready) begin
      rsp_valid_d = d_q.valid;
      rsp_err_d   = d_q.valid & hresp;
      rsp_rdata_d = steer_rdata;
      if (hold_q) begin
        d_d    = XFER_EMPTY;
        hold_d = 1'b0;
      end else begin
        d_d = a_q;
        a_d = XFER_EMPTY;
        if (accept) begin
          a_d.valid = 1'b1;
          a_d.addr  = cmd_addr;
          a_d.write = cmd_write;
          a_d.size  = cmd_size;
          a_d.wdata = cmd_wdata;
        end
      end
    end else if (d_q.valid && hresp) begin
      hold_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples its next-state value from before the edge, independent of order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      a_q         <= XFER_EMPTY;
      d_q         <= XFER_EMPTY;
      hold_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      a_q         <= a_d;
      d_q         <= d_d;
      hold_q      <= hold_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Bench for ahb_lite_master: cycle table, hand-written wait/error/reset
// sequences, then random traffic against a transaction-level model and slave.
module tb_ahb_lite_master;

  logic        clk;
  logic        n_rst;
  logic        cmd_valid, cmd_ready, cmd_write, cmd_size;
  logic [3:0]  cmd_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid, rsp_err, busy;
  logic [15:0] rsp_rdata;
  logic        hsel, hsize, hwrite, hready, hresp;
  logic [3:0]  haddr;
  logic [1:0]  htrans;
  logic [15:0] hwdata, hrdata;

  int n_vec = 0;
  int n_err = 0;

  ahb_lite_master dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_size  (cmd_size),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .hsel      (hsel),
    .haddr     (haddr),
    .hsize     (hsize),
    .htrans    (htrans),
    .hwrite    (hwrite),
    .hwdata    (hwdata),
    .hrdata    (hrdata),
    .hready    (hready),
    .hresp     (hresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int unsigned cv, cw, ca, cs, cwd, hr, hp, hrd;
    int unsigned e_rdy, e_htrans, e_hsel, e_haddr, e_hwrite, e_hsize, e_hwdata;
    int unsigned e_rv, e_rd, e_re, e_busy;
  } vec_t;

  typedef struct {
    int unsigned addr, write, size, wdata, err, waits;
  } plan_t;

  typedef struct {
    int unsigned rdata, err;
  } rsp_t;

  vec_t        tbl[19];
  plan_t       plan_q[$];
  rsp_t        exp_q[$];
  logic [7:0]  ref_mem[16];
  logic [7:0]  slv_mem[16];
  bit          sd_valid = 1'b0;
  plan_t       sd;
  int          sd_wait = 0;
  bit          sd_errph = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drv_cmd(input int unsigned v, input int unsigned w, input int unsigned a,
                         input int unsigned s, input int unsigned d);
    cmd_valid = 1'(v);
    cmd_write = 1'(w);
    cmd_addr  = 4'(a);
    cmd_size  = 1'(s);
    cmd_wdata = 16'(d);
  endtask

  task automatic drv_slv(input int unsigned r, input int unsigned p, input int unsigned d);
    hready = 1'(r);
    hresp  = 1'(p);
    hrdata = 16'(d);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_row(input int idx, input vec_t v);
    drv_cmd(v.cv, v.cw, v.ca, v.cs, v.cwd);
    drv_slv(v.hr, v.hp, v.hrd);
    @(negedge clk);
    check($sformatf("row%0d_cmd_ready", idx), 32'(cmd_ready), v.e_rdy);
    check($sformatf("row%0d_htrans", idx), 32'(htrans), v.e_htrans);
    check($sformatf("row%0d_hsel", idx), 32'(hsel), v.e_hsel);
    check($sformatf("row%0d_haddr", idx), 32'(haddr), v.e_haddr);
    check($sformatf("row%0d_hwrite", idx), 32'(hwrite), v.e_hwrite);
    check($sformatf("row%0d_hsize", idx), 32'(hsize), v.e_hsize);
    check($sformatf("row%0d_hwdata", idx), 32'(hwdata), v.e_hwdata);
    check($sformatf("row%0d_rsp_valid", idx), 32'(rsp_valid), v.e_rv);
    check($sformatf("row%0d_rsp_rdata", idx), 32'(rsp_rdata), v.e_rd);
    check($sformatf("row%0d_rsp_err", idx), 32'(rsp_err), v.e_re);
    check($sformatf("row%0d_busy", idx), 32'(busy), v.e_busy);
    next_cycle();
  endtask

  // One cycle of random traffic: the bench plays the slave (memory, waits,
  // errors) and checks the bus and responses against the command-level model.
  task automatic rand_cycle(input bit allow_cmd);
    plan_t       p, cap;
    rsp_t        r;
    bit          got_cap;
    int unsigned a, e;
    logic [15:0] exp_hw;

    a = sd.addr;
    if (!sd_valid) drv_slv(1, 0, $urandom);
    else if (sd_wait > 0) drv_slv(0, 0, $urandom);
    else if (sd.err == 1) drv_slv(1, 1, 0);
    else if (sd.err == 2) drv_slv(int'(sd_errph), 1, 0);
    else if (sd.write != 0) drv_slv(1, 0, $urandom);
    else drv_slv(1, 0, {16'h0, slv_mem[a | 1], slv_mem[a & 14]});

    if (allow_cmd && $urandom_range(3) != 0) begin
      p.size = $urandom_range(1);
      p.addr = $urandom_range(15);
      if (p.size != 0) p.addr = p.addr & 14;
      drv_cmd(1, $urandom_range(1), p.addr, p.size, $urandom_range(16'hFFFF));
    end else begin
      drv_cmd(0, 0, 0, 0, 0);
    end

    @(negedge clk);
    got_cap = 1'b0;
    cap = '{default: 0};
    if (hready && htrans == 2'b10) begin
      check("bus_hsel", 32'(hsel), 1);
      check("bus_xfer_expected", 32'(plan_q.size() > 0), 1);
      if (plan_q.size() > 0) begin
        cap = plan_q.pop_front();
        got_cap = 1'b1;
        check("bus_haddr", 32'(haddr), cap.addr);
        check("bus_hwrite", 32'(hwrite), cap.write);
        check("bus_hsize", 32'(hsize), cap.size);
      end
    end

    if (sd_valid && hready && sd.write != 0 && sd.err == 0) begin
      exp_hw = (sd.size != 0) ? 16'(sd.wdata) : 16'((sd.wdata % 256) * 257);
      check("bus_hwdata", 32'(hwdata), 32'(exp_hw));
      if (sd.size != 0) begin
        slv_mem[a]     = hwdata[7:0];
        slv_mem[a + 1] = hwdata[15:8];
      end else begin
        slv_mem[a] = (a % 2 == 1) ? hwdata[15:8] : hwdata[7:0];
      end
    end

    if (rsp_valid) begin
      check("rsp_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        r = exp_q.pop_front();
        check("rsp_rdata", 32'(rsp_rdata), r.rdata);
        check("rsp_err", 32'(rsp_err), r.err);
      end
    end

    if (cmd_valid && cmd_ready) begin
      p.addr  = cmd_addr;
      p.write = cmd_write;
      p.size  = cmd_size;
      p.wdata = cmd_wdata;
      e = $urandom_range(9);
      p.err   = (e == 0) ? 1 : (e == 1) ? 2 : 0;
      p.waits = ($urandom_range(3) == 0) ? $urandom_range(2, 1) : 0;
      r.err   = (p.err != 0) ? 1 : 0;
      r.rdata = 0;
      if (p.err == 0 && p.write != 0) begin
        ref_mem[p.addr] = 8'(p.wdata);
        if (p.size != 0) ref_mem[p.addr + 1] = 8'(p.wdata / 256);
      end else if (p.err == 0) begin
        r.rdata = ref_mem[p.addr];
        if (p.size != 0) r.rdata = r.rdata + 256 * ref_mem[p.addr + 1];
      end
      plan_q.push_back(p);
      exp_q.push_back(r);
    end

    if (sd_valid && !hready) begin
      if (sd_wait > 0) sd_wait--;
      else sd_errph = 1'b1;
    end
    if (hready) begin
      sd_valid = got_cap;
      sd       = cap;
      sd_wait  = int'(cap.waits);
      sd_errph = 1'b0;
    end
    next_cycle();
  endtask

  initial begin
    //          cv cw ca cs cwd      hr hp hrd       rdy htr sel adr wr sz hwd      rv rd     re busy
    tbl = '{
      '{1, 1, 6, 1, 'hBEEF, 1, 0, 0,        1, 0, 0, 0, 0, 0, 0,       0, 0,    0, 0},
      '{0, 0, 0, 0, 0,      1, 0, 0,        1, 2, 1, 6, 1, 1, 0,       0, 0,    0, 1},
      '{0, 0, 0, 0, 0,      1, 0, 0,        1, 0, 0, 0, 0, 0, 'hBEEF,  0, 0,    0, 1},
      '{0, 0, 0, 0, 0,      1, 0, 0,        1, 0, 0, 0, 0, 0, 0,       1, 0,    0, 0},
      '{1, 0, 5, 0, 0,      1, 0, 0,        1, 0, 0, 0, 0, 0, 0,       0, 0,    0, 0},
      '{0, 0, 0, 0, 0,      1, 0, 0,        1, 2, 1, 5, 0, 0, 0,       0, 0,    0, 1},
      '{0, 0, 0, 0, 0,      1, 0, 'hA51C,   1, 0, 0, 0, 0, 0, 0,       0, 0,    0, 1},
      '{0, 0, 0, 0, 0,      1, 0, 0,        1, 0, 0, 0, 0, 0, 0,       1, 'hA5, 0, 0},
      '{1, 0, 4, 0, 0,      1, 0, 0,        1, 0, 0, 0, 0, 0, 0,       0, 0,    0, 0},
      '{0, 0, 0, 0, 0,      1, 0, 0,        1, 2, 1, 4, 0, 0, 0,       0, 0,    0, 1},
      '{0, 0, 0, 0, 0,      1, 0, 'hA51C,   1, 0, 0, 0, 0, 0, 0,       0, 0,    0, 1},
      '{0, 0, 0, 0, 0,      1, 0, 0,        1, 0, 0, 0, 0, 0, 0,       1, 'h1C, 0, 0},
      '{1, 1, 4, 0, 'h3412, 1, 0, 0,        1, 0, 0, 0, 0, 0, 0,       0, 0,    0, 0},
      '{1, 1, 5, 0, 'h0056, 1, 0, 0,        1, 2, 1, 4, 1, 0, 0,       0, 0,    0, 1},
      '{1, 0, 4, 0, 0,      1, 0, 0,        1, 2, 1, 5, 1, 0, 'h1212,  0, 0,    0, 1},
      '{0, 0, 0, 0, 0,      1, 0, 0,        1, 2, 1, 4, 0, 0, 'h5656,  1, 0,    0, 1},
      '{0, 0, 0, 0, 0,      1, 0, 'h5612,   1, 0, 0, 0, 0, 0, 0,       1, 0,    0, 1},
      '{0, 0, 0, 0, 0,      1, 0, 0,        1, 0, 0, 0, 0, 0, 0,       1, 'h12, 0, 0},
      '{0, 0, 0, 0, 0,      1, 0, 0,        1, 0, 0, 0, 0, 0, 0,       0, 0,    0, 0}
    };

    n_rst = 1'b0;
    drv_cmd(0, 0, 0, 0, 0);
    drv_slv(1, 0, 0);
    #3;
    check("reset_htrans", 32'(htrans), 0);
    check("reset_hsel", 32'(hsel), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_rsp_valid", 32'(rsp_valid), 0);
    check("reset_cmd_ready", 32'(cmd_ready), 0);
    @(negedge clk);
    n_rst = 1'b1;
    next_cycle();

    for (int i = 0; i < 19; i++) apply_row(i, tbl[i]);

    // Wait states: read 8 stalls two data-phase cycles, write 2 waits in A.
    drv_slv(1, 0, 0);
    drv_cmd(1, 0, 8, 1, 0);
    next_cycle();
    drv_cmd(1, 1, 2, 1, 'h1234);
    @(negedge clk);
    check("ws_haddr8", 32'(haddr), 8);
    check("ws_htrans8", 32'(htrans), 2);
    next_cycle();
    drv_cmd(1, 0, 6, 1, 0);
    drv_slv(0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("ws_frozen_htrans", 32'(htrans), 2);
      check("ws_frozen_haddr", 32'(haddr), 2);
      check("ws_frozen_hwdata", 32'(hwdata), 0);
      check("ws_cmd_ready", 32'(cmd_ready), 0);
      check("ws_no_rsp", 32'(rsp_valid), 0);
      next_cycle();
    end
    drv_slv(1, 0, 'hCAFE);
    @(negedge clk);
    check("ws_release_ready", 32'(cmd_ready), 1);
    check("ws_release_no_rsp", 32'(rsp_valid), 0);
    next_cycle();
    drv_cmd(0, 0, 0, 0, 0);
    drv_slv(1, 0, 0);
    @(negedge clk);
    check("ws_rsp8_valid", 32'(rsp_valid), 1);
    check("ws_rsp8_rdata", 32'(rsp_rdata), 'hCAFE);
    check("ws_next_haddr", 32'(haddr), 6);
    check("ws_next_htrans", 32'(htrans), 2);
    check("ws_w2_hwdata", 32'(hwdata), 'h1234);
    next_cycle();
    drv_slv(1, 0, 'h0BAD);
    @(negedge clk);
    check("ws_rsp2_valid", 32'(rsp_valid), 1);
    check("ws_rsp2_rdata", 32'(rsp_rdata), 0);
    next_cycle();
    drv_slv(1, 0, 0);
    @(negedge clk);
    check("ws_rsp6_valid", 32'(rsp_valid), 1);
    check("ws_rsp6_rdata", 32'(rsp_rdata), 'h0BAD);
    check("ws_idle_busy", 32'(busy), 0);
    next_cycle();

    // Two-cycle error on write 0 with read 6 in the address phase.
    drv_cmd(1, 1, 0, 1, 'h5555);
    next_cycle();
    drv_cmd(1, 0, 6, 1, 0);
    @(negedge clk);
    check("err_haddr0", 32'(haddr), 0);
    next_cycle();
    drv_cmd(0, 0, 0, 0, 0);
    drv_slv(0, 1, 0);
    @(negedge clk);
    check("err1_htrans", 32'(htrans), 2);
    check("err1_haddr", 32'(haddr), 6);
    check("err1_hwdata", 32'(hwdata), 'h5555);
    check("err1_cmd_ready", 32'(cmd_ready), 0);
    next_cycle();
    drv_slv(1, 1, 0);
    @(negedge clk);
    check("err2_htrans", 32'(htrans), 0);
    check("err2_hsel", 32'(hsel), 0);
    check("err2_cmd_ready", 32'(cmd_ready), 0);
    check("err2_busy", 32'(busy), 1);
    next_cycle();
    drv_slv(1, 0, 0);
    @(negedge clk);
    check("err_rsp_valid", 32'(rsp_valid), 1);
    check("err_rsp_err", 32'(rsp_err), 1);
    check("err_replay_htrans", 32'(htrans), 2);
    check("err_replay_haddr", 32'(haddr), 6);
    check("err_replay_hsel", 32'(hsel), 1);
    next_cycle();
    drv_slv(1, 0, 'h7E57);
    @(negedge clk);
    check("err_gap_no_rsp", 32'(rsp_valid), 0);
    next_cycle();
    drv_slv(1, 0, 0);
    @(negedge clk);
    check("err_rd6_valid", 32'(rsp_valid), 1);
    check("err_rd6_err", 32'(rsp_err), 0);
    check("err_rd6_rdata", 32'(rsp_rdata), 'h7E57);
    next_cycle();

    // Single-cycle error: no hold, no replay.
    drv_cmd(1, 0, 3, 0, 0);
    next_cycle();
    drv_cmd(0, 0, 0, 0, 0);
    next_cycle();
    drv_slv(1, 1, 0);
    @(negedge clk);
    check("serr_cmd_ready", 32'(cmd_ready), 0);
    next_cycle();
    drv_slv(1, 0, 0);
    @(negedge clk);
    check("serr_rsp_valid", 32'(rsp_valid), 1);
    check("serr_rsp_err", 32'(rsp_err), 1);
    check("serr_busy", 32'(busy), 0);
    next_cycle();

    // Reset asserted while one transfer is in data phase and one in address.
    drv_cmd(1, 1, 2, 1, 'hAAAA);
    next_cycle();
    drv_cmd(1, 1, 3, 0, 'h00BB);
    next_cycle();
    drv_cmd(0, 0, 0, 0, 0);
    #2;
    check("rst_pre_htrans", 32'(htrans), 2);
    n_rst = 1'b0;
    #1;
    check("rst_htrans", 32'(htrans), 0);
    check("rst_hsel", 32'(hsel), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_cmd_ready", 32'(cmd_ready), 0);
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_no_rsp", 32'(rsp_valid), 0);
    end
    next_cycle();

    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = 8'($urandom);
      slv_mem[i] = ref_mem[i];
    end
    for (int i = 0; i < 3000; i++) rand_cycle(1'b1);
    for (int i = 0; i < 200 && (exp_q.size() > 0 || sd_valid); i++) rand_cycle(1'b0);
    check("drain_outstanding", 32'(exp_q.size()), 0);
    check("drain_unissued", 32'(plan_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
